store_narrow: RTL and testbench
===============================

# store_narrow

Store-path narrowing unit for the pipelined CPU's memory stage; it performs the inverse of immediate/load sign extension. It accepts a 64-bit register value with an access size and base address. It serializes the low 1/2/4/8 bytes little-endian onto a byte-wide data-memory write port, one byte per accepted cycle. It reports whether the truncation lost information, meaning the discarded upper bits were not a valid signed or unsigned extension of the stored field.

## Interface
Parameters:
- DATA_W, 64, width of the register value; fixed at 64 for this CPU.
- ADDR_W, 64, width of byte addresses.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  store request present.
- in_ready  out  1  unit can accept a request.
- in_data  in  DATA_W  value to store.
- in_addr  in  ADDR_W  byte address of the least-significant byte.
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- in_signed  in  1  1 selects the signed overflow check; 0 selects the unsigned check.
- mem_we  out  1  byte write valid.
- mem_addr  out  ADDR_W  byte address of the current write.
- mem_wdata  out  8  byte being written.
- mem_ready  in  1  memory accepts the current byte this cycle.
- done  out  1  one-cycle pulse when the request completes.
- trunc_ovf  out  1  overflow result; valid only while done=1.

## Operation
- FSM states are IDLE, WRITE, DONE. Reset state is IDLE.
- IDLE: in_ready=1. An edge with in_valid=1 captures in_data, in_addr, in_size and the overflow result into registers, loads byte index k=0, and moves to WRITE.
- WRITE: mem_we=1, mem_addr = captured addr + k, mem_wdata = captured data[8k+7:8k].
  - Edge with mem_ready=1: if k = nbytes-1, go to DONE; otherwise k increments.
  - mem_ready=0: all outputs hold unchanged.
  - nbytes = 1 << in_size.
- DONE: done=1 and trunc_ovf holds the captured result. Next edge returns to IDLE.
- in_ready=0 in WRITE and DONE. in_valid and in_data are ignored outside IDLE. Captured values are immune to input changes.
- Overflow check, where N = 8·nbytes:
  - signed: ovf = in_data[63:N-1] not all-equal.
  - unsigned: ovf = in_data[63:N] not all-zero.
  - dword: ovf = 0 always.
- Address arithmetic is modulo 2^ADDR_W, so wrap-around at the top of memory is permitted and not flagged.

## Timing
- Reset values: in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; done=0; trunc_ovf=0. The state register is IDLE and k=0.
- reset_n low mid-transfer aborts immediately, without waiting for a clock edge. Bytes already written are not undone.
- With mem_ready held at 1, accepted at edge 0:
  - bytes appear in cycles 1..nbytes;
  - done is asserted in cycle nbytes+1;
  - the next request can be accepted at the end of cycle nbytes+2.
- Each cycle with mem_ready=0 adds one cycle of latency.
- mem_we, mem_addr, mem_wdata, done and trunc_ovf are all registered-state decodes. They carry no combinational path from in_* inputs.

## Structure
- Package store_pkg holds:
  - the size_e typedef (SZ_B, SZ_H, SZ_W, SZ_D) with 2-bit encoding;
  - the state_e typedef for the FSM states;
  - the function size_bytes(size_e) returning 1/2/4/8.
- Sub-module trunc_check is combinational. Its inputs are data[63:0], size and signed; its output is ovf. It is instantiated once and sampled at acceptance.

## Test plan
- Byte, signed, data 0xFFFF_FFFF_FFFF_FF80, addr 0x100 -> one write of 0x80 @0x100 in cycle 1; done in cycle 2 with trunc_ovf=0.
- Half, unsigned, data 0x0000_0000_0001_1234, addr 0x40 -> 0x34 @0x40, then 0x12 @0x41; done in cycle 3 with trunc_ovf=1.
- Dword 0x0123_4567_89AB_CDEF at 0x200, mem_ready=0 for 3 cycles on byte 2:
  - writes EF,CD,AB,89,67,45,23,01 at 0x200..0x207;
  - byte AB held stable for the whole stall;
  - done in cycle 12 with trunc_ovf=0.
- Word, signed:
  - 0x0000_0000_8000_0000 -> trunc_ovf=1;
  - 0xFFFF_FFFF_8000_0000 -> trunc_ovf=0;
  - the same first value with unsigned check -> trunc_ovf=0.
- reset_n pulsed low after 3 bytes of a dword:
  - mem_we drops to 0 without waiting for a clock edge;
  - in_ready=1 after release;
  - a following byte store at 0x300 completes correctly.
- in_valid held high with in_data changing every cycle during WRITE -> written bytes match the value captured at acceptance. A second request is accepted only in IDLE.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and helpers for the store-path narrowing unit.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int KIDX_W = 3;

    function automatic logic [3:0] size_bytes(input size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/trunc_check.sv
// Combinational truncation check: flags when the bits above the stored field
// are not a valid signed (or unsigned) extension of it.
module trunc_check
    import store_pkg::*;
(
    input  logic [63:0] data_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic        ovf_o
);

    // Signed: the sign bit of the field and everything above must agree.
    always_comb begin
        ovf_o = 1'b0;
        case (size_i)
            SZ_B: ovf_o = signed_i ? ~((&data_i[63:7])  | ~(|data_i[63:7]))  : (|data_i[63:8]);
            SZ_H: ovf_o = signed_i ? ~((&data_i[63:15]) | ~(|data_i[63:15])) : (|data_i[63:16]);
            SZ_W: ovf_o = signed_i ? ~((&data_i[63:31]) | ~(|data_i[63:31])) : (|data_i[63:32]);
            default: ovf_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// Store-path narrowing unit: serializes the low 1/2/4/8 bytes of a register
// little-endian onto a byte-wide write port and reports truncation overflow.
//
// state | meaning
// IDLE  | ready for a request; capture on in_valid
// WRITE | present byte k; advance on mem_ready
// DONE  | one-cycle completion pulse with captured trunc_ovf
module store_narrow
    import store_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              trunc_ovf
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    size_e               size_q, size_d;
    logic                ovf_q, ovf_d;
    logic [KIDX_W-1:0]   k_q, k_d;
    logic                ovf_now;
    logic                last_byte;

    trunc_check u_trunc_check (
        .data_i   (in_data),
        .size_i   (size_e'(in_size)),
        .signed_i (in_signed),
        .ovf_o    (ovf_now)
    );

    assign last_byte = ({1'b0, k_q} == (size_bytes(size_q) - 4'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            size_q  <= SZ_B;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    addr_d  = in_addr;
                    size_d  = size_e'(in_size);
                    ovf_d   = ovf_now;
                    k_d     = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; idle values are zero.
    assign in_ready  = (state_q == IDLE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_we ? (addr_q + ADDR_W'(k_q)) : '0;
    assign mem_wdata = mem_we ? data_q[{k_q, 3'b000} +: 8] : 8'h00;
    assign done      = (state_q == DONE);
    assign trunc_ovf = done & ovf_q;

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow: transaction-level reference model plus
// directed stores with hand-computed completion cycles and overflow results.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [63:0] in_addr = '0;
    logic [1:0]  in_size = '0;
    logic        in_signed = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready = 1'b1;
    logic        done;
    logic        trunc_ovf;

    always #5 clk = ~clk;

    store_narrow #(.DATA_W(64), .ADDR_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .in_signed (in_signed),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .done      (done),
        .trunc_ovf (trunc_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a request becomes a list of (address, byte) writes and
    // an overflow flag computed from the numeric range of the stored field.
    typedef struct {
        logic [63:0] a;
        logic [7:0]  b;
    } wr_t;

    wr_t  wq[$];
    logic exp_ovf = 1'b0;
    int   ph = 0;

    function automatic logic model_ovf(input logic [63:0] d, input logic [1:0] sz, input logic sg);
        int     n = 8 << sz;
        longint v = $signed(d);
        longint lim;
        if (n == 64) return 1'b0;
        if (sg) begin
            lim = longint'(1) <<< (n - 1);
            return (v < -lim) || (v > lim - 1);
        end
        return d >= (64'd1 << n);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ph = 0;
                wq.delete();
            end else begin
                case (ph)
                    0: begin
                        check("idle_in_ready", in_ready, 1);
                        check("idle_mem_we", mem_we, 0);
                        check("idle_done", done, 0);
                        if (in_valid) begin
                            for (int i = 0; i < (1 << in_size); i++)
                                wq.push_back('{a: in_addr + 64'(i), b: 8'(in_data >> (8 * i))});
                            exp_ovf = model_ovf(in_data, in_size, in_signed);
                            ph = 1;
                        end
                    end
                    1: begin
                        check("write_in_ready", in_ready, 0);
                        check("write_mem_we", mem_we, 1);
                        check("write_done", done, 0);
                        check("write_addr", mem_addr, wq[0].a);
                        check("write_data", {56'd0, mem_wdata}, {56'd0, wq[0].b});
                        if (mem_ready) begin
                            void'(wq.pop_front());
                            if (wq.size() == 0) ph = 2;
                        end
                    end
                    default: begin
                        check("done_pulse", done, 1);
                        check("done_ovf", trunc_ovf, exp_ovf);
                        check("done_mem_we", mem_we, 0);
                        check("done_in_ready", in_ready, 0);
                        ph = 0;
                    end
                endcase
            end
        end
    end

    task automatic wait_idle(input string nm);
        int c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!in_ready && c < 50);
        check({nm, "_idle_wait"}, in_ready, 1);
    endtask

    // Edge 0 is the accepting edge; cycle c lies between edges c-1 and c.
    task automatic store(input logic [63:0] d, input logic [63:0] a, input logic [1:0] sz,
                         input logic sg, input int ss, input int sl, input bit hold,
                         input int exp_done, input logic exp_o, input string nm);
        int       c;
        bit       seen = 0;
        bit       have_stall = 0;
        logic [7:0] sv = '0;
        wait_idle(nm);
        in_valid  = 1'b1;
        in_data   = d;
        in_addr   = a;
        in_size   = sz;
        in_signed = sg;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        for (c = 1; c <= 40; c++) begin
            mem_ready = !(c >= ss && c < ss + sl);
            if (hold) in_data = {$urandom, $urandom};
            @(negedge clk);
            if (!mem_ready && mem_we) begin
                if (!have_stall) begin
                    sv = mem_wdata;
                    have_stall = 1;
                end else begin
                    check({nm, "_stall_hold"}, {56'd0, mem_wdata}, {56'd0, sv});
                end
            end
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check({nm, "_done_cycle"}, seen ? 64'(c) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_done));
        check({nm, "_ovf"}, trunc_ovf, exp_o);
        mem_ready = 1'b1;
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", {56'd0, mem_wdata}, 0);
        check("rst_done", done, 0);
        check("rst_trunc_ovf", trunc_ovf, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        store(64'hFFFF_FFFF_FFFF_FF80, 64'h100, 2'b00, 1'b1, 0, 0, 0, 2, 1'b0, "byte_s");
        store(64'h0000_0000_0001_1234, 64'h40,  2'b01, 1'b0, 0, 0, 0, 3, 1'b1, "half_u");
        store(64'h0123_4567_89AB_CDEF, 64'h200, 2'b11, 1'b0, 3, 3, 0, 12, 1'b0, "dword_stall");
        store(64'h0000_0000_8000_0000, 64'h10,  2'b10, 1'b1, 0, 0, 0, 5, 1'b1, "word_s_pos");
        store(64'hFFFF_FFFF_8000_0000, 64'h20,  2'b10, 1'b1, 0, 0, 0, 5, 1'b0, "word_s_neg");
        store(64'h0000_0000_8000_0000, 64'h30,  2'b10, 1'b0, 0, 0, 0, 5, 1'b0, "word_u");
        store(64'h0000_0000_0000_0100, 64'h50,  2'b00, 1'b0, 0, 0, 0, 2, 1'b1, "byte_u_ovf");
        store(64'h0000_0000_0000_007F, 64'h51,  2'b00, 1'b1, 0, 0, 0, 2, 1'b0, "byte_s_max");
        store(64'hFFFF_FFFF_FFFF_FF7F, 64'h52,  2'b00, 1'b1, 0, 0, 0, 2, 1'b1, "byte_s_under");
        store(64'h0000_0000_0000_ABCD, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 0, 0, 0, 3, 1'b0, "half_wrap");

        // Asynchronous abort during the fourth byte of a dword.
        wait_idle("abort");
        in_valid  = 1'b1;
        in_data   = 64'h1122_3344_5566_7788;
        in_addr   = 64'h500;
        in_size   = 2'b11;
        in_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("abort_pre_we", mem_we, 1);
        check("abort_pre_data", {56'd0, mem_wdata}, 64'h55);
        reset_n = 1'b0;
        #1;
        check("abort_mem_we", mem_we, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("abort_release_ready", in_ready, 1);
        store(64'h0000_0000_0000_005A, 64'h300, 2'b00, 1'b0, 0, 0, 0, 2, 1'b0, "after_abort");

        // in_valid held with churning data; the follow-up waits for IDLE.
        store(64'h0000_0000_DEAD_BEEF, 64'h400, 2'b10, 1'b0, 0, 0, 1, 5, 1'b0, "hold_word");
        store(64'h0000_0000_0000_0077, 64'h410, 2'b00, 1'b0, 0, 0, 0, 2, 1'b0, "hold_next");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
